// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: load formatting, GPR write port, return buffer, retire counter.
// Optional WB_DEBUG_TRACE_EN adds the PC register and debug_wb_* trace ports.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid_w_i,
  output logic        WB_allowin_w_o,
  input  logic        CP0_excOccur_w_i,
  input  logic [4:0]  MEM_writeNum_i,
  input  logic [31:0] MEM_finalRes_i,
  input  logic        MEM_memReq_i,
  input  logic [2:0]  MEM_loadSel_i,
  input  logic [1:0]  MEM_alignCheck_i,
  input  logic [31:0] MEM_rtData_i,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        WB_writeEnable_w_o,
  output logic [4:0]  WB_writeNum_w_o,
  output logic [31:0] WB_writeData_w_o,
  output logic        WB_forwardMode_w_o,
`ifdef WB_DEBUG_TRACE_EN
  input  logic [31:0] MEM_pc_i,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
`endif
  output logic [31:0] WB_retireCount_o
);

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  logic        take;

  logic        has_data_q,   has_data_d;
  logic        pending_q,    pending_d;
  logic [31:0] rbuf_q,       rbuf_d;
  logic [4:0]  write_num_q,  write_num_d;
  logic        mem_req_q,    mem_req_d;
  logic [2:0]  load_sel_q,   load_sel_d;
  logic [1:0]  offset_q,     offset_d;
  logic [31:0] rt_data_q,    rt_data_d;
  logic [31:0] word_q,       word_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] pc_q,         pc_d;
`endif

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] fmt_data;

  assign WB_allowin_w_o = !rst;
  assign take = MEM_valid_w_i && WB_allowin_w_o && !CP0_excOccur_w_i;

  always_comb begin
    has_data_d   = take;
    pending_d    = pending_q;
    rbuf_d       = rbuf_q;
    write_num_d  = write_num_q;
    mem_req_d    = mem_req_q;
    load_sel_d   = load_sel_q;
    offset_d     = offset_q;
    rt_data_d    = rt_data_q;
    word_d       = word_q;
    retire_cnt_d = has_data_q ? retire_cnt_q + 32'd1 : retire_cnt_q;
`ifdef WB_DEBUG_TRACE_EN
    pc_d         = pc_q;
`endif

    if (take) begin
      write_num_d = MEM_writeNum_i;
      mem_req_d   = MEM_memReq_i;
      load_sel_d  = MEM_loadSel_i;
      offset_d    = MEM_alignCheck_i;
      rt_data_d   = MEM_rtData_i;
      word_d      = MEM_memReq_i ? (pending_q ? rbuf_q : data_rdata) : MEM_finalRes_i;
`ifdef WB_DEBUG_TRACE_EN
      pc_d        = MEM_pc_i;
`endif
    end

    // A flush drops both the buffered return and any return arriving with it.
    if (CP0_excOccur_w_i) begin
      pending_d = 1'b0;
    end else if (take && MEM_memReq_i) begin
      pending_d = 1'b0;
    end else if (data_data_ok) begin
      pending_d = 1'b1;
      rbuf_d    = data_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_data_q   <= 1'b0;
      pending_q    <= 1'b0;
      rbuf_q       <= 32'd0;
      write_num_q  <= 5'd0;
      mem_req_q    <= 1'b0;
      load_sel_q   <= 3'd0;
      offset_q     <= 2'd0;
      rt_data_q    <= 32'd0;
      word_q       <= 32'd0;
      retire_cnt_q <= 32'd0;
`ifdef WB_DEBUG_TRACE_EN
      pc_q         <= 32'd0;
`endif
    end else begin
      has_data_q   <= has_data_d;
      pending_q    <= pending_d;
      rbuf_q       <= rbuf_d;
      write_num_q  <= write_num_d;
      mem_req_q    <= mem_req_d;
      load_sel_q   <= load_sel_d;
      offset_q     <= offset_d;
      rt_data_q    <= rt_data_d;
      word_q       <= word_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef WB_DEBUG_TRACE_EN
      pc_q         <= pc_d;
`endif
    end
  end

  always_comb begin
    ld_byte  = word_q[7:0];
    ld_half  = offset_q[1] ? word_q[31:16] : word_q[15:0];
    fmt_data = word_q;

    case (offset_q)
      2'd0:    ld_byte = word_q[7:0];
      2'd1:    ld_byte = word_q[15:8];
      2'd2:    ld_byte = word_q[23:16];
      default: ld_byte = word_q[31:24];
    endcase

    if (mem_req_q) begin
      case (load_sel_q)
        LD_LB:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
        LD_LBU: fmt_data = {24'd0, ld_byte};
        LD_LH:  fmt_data = {{16{ld_half[15]}}, ld_half};
        LD_LHU: fmt_data = {16'd0, ld_half};
        LD_LWL: begin
          case (offset_q)
            2'd0:    fmt_data = {word_q[7:0],  rt_data_q[23:0]};
            2'd1:    fmt_data = {word_q[15:0], rt_data_q[15:0]};
            2'd2:    fmt_data = {word_q[23:0], rt_data_q[7:0]};
            default: fmt_data = word_q;
          endcase
        end
        LD_LWR: begin
          case (offset_q)
            2'd0:    fmt_data = word_q;
            2'd1:    fmt_data = {rt_data_q[31:24], word_q[31:8]};
            2'd2:    fmt_data = {rt_data_q[31:16], word_q[31:16]};
            default: fmt_data = {rt_data_q[31:8],  word_q[31:24]};
          endcase
        end
        default: fmt_data = word_q;
      endcase
    end
  end

  assign WB_writeEnable_w_o = has_data_q && (write_num_q != 5'd0);
  assign WB_writeNum_w_o    = write_num_q;
  assign WB_writeData_w_o   = fmt_data;
  assign WB_forwardMode_w_o = has_data_q;
  assign WB_retireCount_o   = retire_cnt_q;

`ifdef WB_DEBUG_TRACE_EN
  always_comb begin
    debug_wb_rf_wen = 4'b0000;
    if (WB_writeEnable_w_o) begin
      debug_wb_rf_wen = 4'b1111;
      if (mem_req_q && load_sel_q == LD_LWL) begin
        case (offset_q)
          2'd0:    debug_wb_rf_wen = 4'b1000;
          2'd1:    debug_wb_rf_wen = 4'b1100;
          2'd2:    debug_wb_rf_wen = 4'b1110;
          default: debug_wb_rf_wen = 4'b1111;
        endcase
      end else if (mem_req_q && load_sel_q == LD_LWR) begin
        case (offset_q)
          2'd0:    debug_wb_rf_wen = 4'b1111;
          2'd1:    debug_wb_rf_wen = 4'b0111;
          2'd2:    debug_wb_rf_wen = 4'b0011;
          default: debug_wb_rf_wen = 4'b0001;
        endcase
      end
    end
  end

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wnum  = WB_writeNum_w_o;
  assign debug_wb_rf_wdata = WB_writeData_w_o;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        MEM_valid_w_i;
  logic        WB_allowin_w_o;
  logic        CP0_excOccur_w_i;
  logic [4:0]  MEM_writeNum_i;
  logic [31:0] MEM_finalRes_i;
  logic        MEM_memReq_i;
  logic [2:0]  MEM_loadSel_i;
  logic [1:0]  MEM_alignCheck_i;
  logic [31:0] MEM_rtData_i;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        WB_writeEnable_w_o;
  logic [4:0]  WB_writeNum_w_o;
  logic [31:0] WB_writeData_w_o;
  logic        WB_forwardMode_w_o;
  logic [31:0] WB_retireCount_o;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] MEM_pc_i;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_cnt = 32'd0;

  wb_stage dut (
    .clk                (clk),
    .rst                (rst),
    .MEM_valid_w_i      (MEM_valid_w_i),
    .WB_allowin_w_o     (WB_allowin_w_o),
    .CP0_excOccur_w_i   (CP0_excOccur_w_i),
    .MEM_writeNum_i     (MEM_writeNum_i),
    .MEM_finalRes_i     (MEM_finalRes_i),
    .MEM_memReq_i       (MEM_memReq_i),
    .MEM_loadSel_i      (MEM_loadSel_i),
    .MEM_alignCheck_i   (MEM_alignCheck_i),
    .MEM_rtData_i       (MEM_rtData_i),
    .data_data_ok       (data_data_ok),
    .data_rdata         (data_rdata),
    .WB_writeEnable_w_o (WB_writeEnable_w_o),
    .WB_writeNum_w_o    (WB_writeNum_w_o),
    .WB_writeData_w_o   (WB_writeData_w_o),
    .WB_forwardMode_w_o (WB_forwardMode_w_o),
`ifdef WB_DEBUG_TRACE_EN
    .MEM_pc_i           (MEM_pc_i),
    .debug_wb_pc        (debug_wb_pc),
    .debug_wb_rf_wen    (debug_wb_rf_wen),
    .debug_wb_rf_wnum   (debug_wb_rf_wnum),
    .debug_wb_rf_wdata  (debug_wb_rf_wdata),
`endif
    .WB_retireCount_o   (WB_retireCount_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_valid_w_i    = 1'b0;
    CP0_excOccur_w_i = 1'b0;
    MEM_writeNum_i   = 5'd0;
    MEM_finalRes_i   = 32'd0;
    MEM_memReq_i     = 1'b0;
    MEM_loadSel_i    = 3'd0;
    MEM_alignCheck_i = 2'd0;
    MEM_rtData_i     = 32'd0;
    data_data_ok     = 1'b0;
    data_rdata       = 32'd0;
`ifdef WB_DEBUG_TRACE_EN
    MEM_pc_i         = 32'd0;
`endif
  endtask

  task automatic offer_load(input logic [2:0] sel, input logic [1:0] off, input logic [4:0] wn,
                            input logic [31:0] rt, input logic ok, input logic [31:0] rdata);
    MEM_valid_w_i    = 1'b1;
    MEM_memReq_i     = 1'b1;
    MEM_loadSel_i    = sel;
    MEM_alignCheck_i = off;
    MEM_writeNum_i   = wn;
    MEM_rtData_i     = rt;
    data_data_ok     = ok;
    data_rdata       = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_checks++;
    if (WB_allowin_w_o !== 1'b0) begin n_fail++; $display("FAIL reset_allowin: got %b expected 0", WB_allowin_w_o); end
    n_checks++;
    if ({WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o, WB_forwardMode_w_o} !== 39'd0) begin
      n_fail++; $display("FAIL reset_outputs: got wen=%b wnum=%0d wdata=%h fwd=%b expected all 0",
                         WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o, WB_forwardMode_w_o);
    end
    n_checks++;
    if (WB_retireCount_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", WB_retireCount_o); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (WB_allowin_w_o !== 1'b1) begin n_fail++; $display("FAIL allowin_after_reset: got %b expected 1", WB_allowin_w_o); end
  endtask

  task automatic test_lb();
    offer_load(3'd1, 2'd3, 5'd5, 32'h0, 1'b1, 32'h80FF_0000);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b1 || WB_writeNum_w_o !== 5'd5) begin
      n_fail++; $display("FAIL lb_wen_wnum: got wen=%b wnum=%0d expected wen=1 wnum=5", WB_writeEnable_w_o, WB_writeNum_w_o);
    end
    n_checks++;
    if (WB_writeData_w_o !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_wdata: got %h expected ffffff80", WB_writeData_w_o); end
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b0 || WB_forwardMode_w_o !== 1'b0) begin
      n_fail++; $display("FAIL lb_one_cycle: got wen=%b fwd=%b expected 0 0", WB_writeEnable_w_o, WB_forwardMode_w_o);
    end
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL lb_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
  endtask

  task automatic test_lwl_lwr();
    offer_load(3'd6, 2'd2, 5'd7, 32'h1122_3344, 1'b1, 32'hAABB_CCDD);
`ifdef WB_DEBUG_TRACE_EN
    MEM_pc_i = 32'hBFC0_0010;
`endif
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'h1122_AABB || WB_writeNum_w_o !== 5'd7 || WB_writeEnable_w_o !== 1'b1) begin
      n_fail++; $display("FAIL lwr_o2: got wen=%b wnum=%0d wdata=%h expected 1 7 1122aabb",
                         WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o);
    end
`ifdef WB_DEBUG_TRACE_EN
    n_checks++;
    if (debug_wb_rf_wen !== 4'b0011 || debug_wb_pc !== 32'hBFC0_0010 || debug_wb_rf_wdata !== 32'h1122_AABB ||
        debug_wb_rf_wnum !== 5'd7) begin
      n_fail++; $display("FAIL lwr_debug: got wen=%b pc=%h wnum=%0d wdata=%h expected 0011 bfc00010 7 1122aabb",
                         debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
`endif
    exp_cnt = exp_cnt + 1;
    offer_load(3'd5, 2'd1, 5'd8, 32'h1122_3344, 1'b1, 32'hAABB_CCDD);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'hCCDD_3344) begin n_fail++; $display("FAIL lwl_o1: got %h expected ccdd3344", WB_writeData_w_o); end
`ifdef WB_DEBUG_TRACE_EN
    n_checks++;
    if (debug_wb_rf_wen !== 4'b1100) begin n_fail++; $display("FAIL lwl_debug_wen: got %b expected 1100", debug_wb_rf_wen); end
`endif
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL lwx_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    offer_load(3'd3, 2'd0, 5'd3, 32'h0, 1'b1, 32'h1234_8765);
    tick();
    offer_load(3'd4, 2'd2, 5'd4, 32'h0, 1'b1, 32'h8001_7FFF);
    n_checks++;
    if (WB_writeData_w_o !== 32'hFFFF_8765 || WB_writeNum_w_o !== 5'd3) begin
      n_fail++; $display("FAIL b2b_lh: got wnum=%0d wdata=%h expected 3 ffff8765", WB_writeNum_w_o, WB_writeData_w_o);
    end
    tick();
    offer_load(3'd2, 2'd1, 5'd6, 32'h0, 1'b1, 32'h0000_9A00);
    n_checks++;
    if (WB_writeData_w_o !== 32'h0000_8001 || WB_writeNum_w_o !== 5'd4 || WB_writeEnable_w_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_lhu: got wen=%b wnum=%0d wdata=%h expected 1 4 00008001",
                         WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'h0000_009A || WB_writeNum_w_o !== 5'd6 || WB_writeEnable_w_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_lbu: got wen=%b wnum=%0d wdata=%h expected 1 6 0000009a",
                         WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o);
    end
    exp_cnt = exp_cnt + 3;
    tick();
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
  endtask

  task automatic test_return_buffer();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    tick();
    idle_inputs();
    tick();
    offer_load(3'd0, 2'd0, 5'd10, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'h1234_5678 || WB_writeEnable_w_o !== 1'b1) begin
      n_fail++; $display("FAIL buf_lw: got wen=%b wdata=%h expected 1 12345678", WB_writeEnable_w_o, WB_writeData_w_o);
    end
    exp_cnt = exp_cnt + 1;
    tick();
    offer_load(3'd0, 2'd0, 5'd11, 32'h0, 1'b1, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL buf_cleared: got %h expected cafef00d", WB_writeData_w_o); end
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL buf_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
  endtask

  task automatic test_flush();
    data_data_ok = 1'b1;
    data_rdata   = 32'h55AA_55AA;
    tick();
    idle_inputs();
    offer_load(3'd0, 2'd0, 5'd9, 32'h0, 1'b0, 32'h0);
    CP0_excOccur_w_i = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b0 || WB_forwardMode_w_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_write: got wen=%b fwd=%b expected 0 0", WB_writeEnable_w_o, WB_forwardMode_w_o);
    end
    tick();
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
    offer_load(3'd0, 2'd0, 5'd12, 32'h0, 1'b1, 32'h0F0F_0F0F);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL flush_pending_clear: got %h expected 0f0f0f0f", WB_writeData_w_o); end
    exp_cnt = exp_cnt + 1;
    CP0_excOccur_w_i = 1'b1;
    data_data_ok     = 1'b1;
    data_rdata       = 32'hBAD0_BAD0;
    tick();
    idle_inputs();
    offer_load(3'd0, 2'd0, 5'd13, 32'h0, 1'b1, 32'h0000_600D);
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeData_w_o !== 32'h0000_600D) begin n_fail++; $display("FAIL flush_drop_return: got %h expected 0000600d", WB_writeData_w_o); end
    exp_cnt = exp_cnt + 1;
    tick();
  endtask

  task automatic test_nonload_r0();
    MEM_valid_w_i  = 1'b1;
    MEM_finalRes_i = 32'hDEAD_BEEF;
    MEM_writeNum_i = 5'd0;
    MEM_loadSel_i  = 3'd1;
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b0 || WB_forwardMode_w_o !== 1'b1 || WB_writeData_w_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL nonload_r0: got wen=%b fwd=%b wdata=%h expected 0 1 deadbeef",
                         WB_writeEnable_w_o, WB_forwardMode_w_o, WB_writeData_w_o);
    end
    exp_cnt = exp_cnt + 1;
    tick();
    n_checks++;
    if (WB_retireCount_o !== exp_cnt) begin n_fail++; $display("FAIL nonload_count: got %0d expected %0d", WB_retireCount_o, exp_cnt); end
  endtask

  task automatic test_async_reset();
    MEM_valid_w_i  = 1'b1;
    MEM_finalRes_i = 32'h1357_9BDF;
    MEM_writeNum_i = 5'd2;
    tick();
    idle_inputs();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_write: got wen=%b expected 1", WB_writeEnable_w_o); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o, WB_forwardMode_w_o, WB_allowin_w_o} !== 40'd0) begin
      n_fail++; $display("FAIL arst_outputs: got wen=%b wnum=%0d wdata=%h fwd=%b allowin=%b expected all 0",
                         WB_writeEnable_w_o, WB_writeNum_w_o, WB_writeData_w_o, WB_forwardMode_w_o, WB_allowin_w_o);
    end
    n_checks++;
    if (WB_retireCount_o !== 32'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", WB_retireCount_o); end
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (WB_writeEnable_w_o !== 1'b0 || WB_retireCount_o !== 32'd0) begin
      n_fail++; $display("FAIL arst_after: got wen=%b count=%0d expected 0 0", WB_writeEnable_w_o, WB_retireCount_o);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_lb();
    test_lwl_lwr();
    test_back_to_back();
    test_return_buffer();
    test_flush();
    test_nonload_r0();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
